sr_latch_bank: RTL

Parametrised, clocked successor to the single NAND SR latch. It provides WIDTH independent SR storage channels, each with a per-channel input glitch filter and enable. The S=R=1 resolution policy is selectable, and conflict reporting and counting are built in. It sits between raw set/clear request lines (status flags, interrupt-style requests) and register/status logic that needs glitch-free, never-invalid flag state.

---
 rtl/sr_latch_bank_pkg.sv | 34 +++
 rtl/sr_glitch_filter.sv | 65 ++++++
 rtl/sr_latch_bank.sv | 114 +++++++++++
 3 files changed

// File: rtl/sr_latch_bank_pkg.sv
// sr_latch_bank_pkg
// Shared constants and types for the clocked SR latch bank.
//   MODE_*  : resolution policies for an accepted S=R=1 pair
//   CNT_W   : width of the conflict edge counter
//   CNT_MAX : saturation value of the conflict edge counter
//   sr_pair_e     : {s,r} pair encoding
//   resolve_both  : next q for an accepted 11 pair under a given policy
package sr_latch_bank_pkg;

  localparam int MODE_HOLD   = 0;
  localparam int MODE_SET    = 1;
  localparam int MODE_RST    = 2;
  localparam int MODE_TOGGLE = 3;

  localparam int              CNT_W   = 8;
  localparam logic [CNT_W-1:0] CNT_MAX = 8'd255;

  typedef enum logic [1:0] {
    PAIR_HOLD = 2'b00,
    PAIR_RST  = 2'b01,
    PAIR_SET  = 2'b10,
    PAIR_BOTH = 2'b11
  } sr_pair_e;

  function automatic logic resolve_both(input int mode, input logic q_cur);
    case (mode)
      MODE_SET:    return 1'b1;
      MODE_RST:    return 1'b0;
      MODE_TOGGLE: return ~q_cur;
      default:     return q_cur;
    endcase
  endfunction

endpackage

// File: rtl/sr_glitch_filter.sv
// sr_glitch_filter
// One-channel input qualifier for a {s,r} request pair. A pair is accepted
// once it has been sampled unchanged on FILT+1 consecutive rising edges,
// and stays accepted for as long as it persists. FILT=0 bypasses the filter.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   s, r       : raw request pair
//   clr        : synchronous restart of qualification (candidate 00)
//   acc_valid  : pair on this edge is qualified
//   acc_pair   : the qualified {s,r} pair (meaningful when acc_valid=1)
module sr_glitch_filter
  import sr_latch_bank_pkg::*;
#(
  parameter int FILT = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       s,
  input  logic       r,
  input  logic       clr,
  output logic       acc_valid,
  output logic [1:0] acc_pair
);

  logic [1:0] raw_pair;
  assign raw_pair = {s, r};

  generate
    if (FILT == 0) begin : g_bypass
      // No state at all: every edge acts on the raw pair.
      logic unused_ok;
      assign unused_ok = ^{clk, rst_n, clr};
      assign acc_valid = 1'b1;
      assign acc_pair  = raw_pair;
    end else begin : g_filter
      localparam int              CW      = $clog2(FILT + 1);
      localparam logic [CW-1:0]   CNT_SAT = CW'(FILT);
      localparam logic [CW:0]     ACC_LIM = (CW + 1)'(FILT);

      logic [1:0]    cand_reg;
      logic [CW-1:0] cnt_reg;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          cand_reg <= 2'b00;
          cnt_reg  <= '0;
        end else if (clr) begin
          cand_reg <= 2'b00;
          cnt_reg  <= '0;
        end else if (raw_pair != cand_reg) begin
          cand_reg <= raw_pair;
          cnt_reg  <= '0;
        end else if (cnt_reg != CNT_SAT) begin
          cnt_reg <= cnt_reg + CW'(1);
        end
      end

      // cnt_reg counts repeats after the sample that loaded the candidate,
      // so cnt_reg+1 >= FILT means this edge is sample number FILT+1 or later.
      assign acc_valid = (raw_pair == cand_reg) && (({1'b0, cnt_reg} + (CW + 1)'(1)) >= ACC_LIM);
      assign acc_pair  = cand_reg;
    end
  endgenerate

endmodule

// File: rtl/sr_latch_bank.sv
// sr_latch_bank
// WIDTH independent clocked SR storage channels with per-channel glitch
// filtering and enable, a selectable S=R=1 policy and conflict reporting.
// Ports:
//   clk, rst_n      : clock, asynchronous active-low reset
//   s, r, en        : per-channel set / reset requests and update enable
//   clr             : synchronous clear of all state (highest priority)
//   q, qbar         : stored state and its registered complement
//   conflict        : per channel, accepted 11 pair acted on last edge
//   conflict_sticky : any conflict since last clr/reset
//   conflict_cnt    : saturating count of edges with any conflict
module sr_latch_bank
  import sr_latch_bank_pkg::*;
#(
  parameter int               WIDTH   = 8,
  parameter int               MODE    = MODE_HOLD,
  parameter int               FILT    = 2,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] s,
  input  logic [WIDTH-1:0] r,
  input  logic [WIDTH-1:0] en,
  input  logic             clr,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qbar,
  output logic [WIDTH-1:0] conflict,
  output logic             conflict_sticky,
  output logic [CNT_W-1:0] conflict_cnt
);

  logic [WIDTH-1:0] q_reg, q_next;
  logic [WIDTH-1:0] qbar_reg;
  logic [WIDTH-1:0] conflict_reg, conflict_next;
  logic             sticky_reg;
  logic [CNT_W-1:0] cnt_reg;

  logic [WIDTH-1:0] acc_valid;
  logic [1:0]       acc_pair [WIDTH];

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_chan
      logic q_nx;
      logic conf_nx;

      sr_glitch_filter #(
        .FILT(FILT)
      ) u_filt (
        .clk      (clk),
        .rst_n    (rst_n),
        .s        (s[gi]),
        .r        (r[gi]),
        .clr      (clr),
        .acc_valid(acc_valid[gi]),
        .acc_pair (acc_pair[gi])
      );

      always_comb begin
        q_nx    = q_reg[gi];
        conf_nx = 1'b0;
        if (acc_valid[gi] && en[gi]) begin
          case (sr_pair_e'(acc_pair[gi]))
            PAIR_SET:  q_nx = 1'b1;
            PAIR_RST:  q_nx = 1'b0;
            PAIR_BOTH: begin
              q_nx    = resolve_both(MODE, q_reg[gi]);
              conf_nx = 1'b1;
            end
            default:   q_nx = q_reg[gi];
          endcase
        end
      end

      assign q_next[gi]        = q_nx;
      assign conflict_next[gi] = conf_nx;
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_reg        <= RST_VAL;
      qbar_reg     <= ~RST_VAL;
      conflict_reg <= '0;
      sticky_reg   <= 1'b0;
      cnt_reg      <= '0;
    end else if (clr) begin
      q_reg        <= RST_VAL;
      qbar_reg     <= ~RST_VAL;
      conflict_reg <= '0;
      sticky_reg   <= 1'b0;
      cnt_reg      <= '0;
    end else begin
      q_reg        <= q_next;
      // Complement taken from the same next-state value, so qbar can never
      // disagree with q.
      qbar_reg     <= ~q_next;
      conflict_reg <= conflict_next;
      if (|conflict_next) begin
        sticky_reg <= 1'b1;
        // One count per conflicting edge, regardless of how many channels.
        if (cnt_reg != CNT_MAX) cnt_reg <= cnt_reg + 8'd1;
      end
    end
  end

  assign q               = q_reg;
  assign qbar            = qbar_reg;
  assign conflict        = conflict_reg;
  assign conflict_sticky = sticky_reg;
  assign conflict_cnt    = cnt_reg;

endmodule
